riscv_div_sequencer: RTL and testbench
======================================

Name: riscv_div_sequencer

Overview:
- Controller between the execute stage and the iterative unsigned divider.
- Accepts DIV/DIVU/REM/REMU requests over a valid/ready handshake.
- Resolves RISC-V special cases without using the divider, feeds the divider operand magnitudes, and applies sign fixup to its results.
- Keeps a one-entry result cache, so a DIV followed by a REM on the same operands costs one divider pass. Also handles pipeline flush, including a divider operation already in flight.

Parameters:
- WIDTH, 32, operand/result width.
- CACHE_EN, 1, 1 enables the one-entry quotient/remainder cache; 0 makes every non-special request use the divider.

Ports:
- clk_in  input  1  clock
- rst_in  input  1  reset, asynchronous, active-low
- req_valid_in  input  1  request valid
- req_ready_out  output  1  sequencer can accept a request
- req_op_in  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- req_a_in  input  WIDTH  dividend
- req_b_in  input  WIDTH  divisor
- resp_valid_out  output  1  result valid
- resp_ready_in  input  1  consumer takes result
- resp_result_out  output  WIDTH  result
- flush_in  input  1  kill pending request or response
- div_start_out  output  1  one-cycle start pulse to the divider
- div_dividend_out  output  WIDTH  unsigned dividend magnitude
- div_divisor_out  output  WIDTH  unsigned divisor magnitude
- div_done_in  input  1  divider result valid (one-cycle pulse)
- div_quotient_in  input  WIDTH  unsigned quotient
- div_remainder_in  input  WIDTH  unsigned remainder

Behaviour:
- Reset (rst_in low, asynchronous):
  - State goes to IDLE; cache valid bit cleared.
  - Outputs: req_ready_out=0 while reset is asserted, then 1. resp_valid_out=0, resp_result_out=0, div_start_out=0, div_dividend_out=0, div_divisor_out=0.
- States: IDLE, ISSUE, WAIT, DONE, DRAIN.
- IDLE:
  - req_ready_out=1.
  - On req_valid_in, latch op/a/b. signed = !op[0].
- Classification at accept, in priority order:
  - b==0: quotient=all ones; remainder=a.
  - signed and a=0x8000_0000 and b=all ones: quotient=0x8000_0000; remainder=0.
  - Cache hit (CACHE_EN and cache valid and a, b, signed all match): use the stored quotient/remainder.
  - Each of the three cases above goes to DONE on the next cycle.
  - Otherwise go to ISSUE.
- ISSUE:
  - div_start_out=1 for exactly one cycle.
  - div_dividend_out = |a| if signed else a; div_divisor_out = |b| if signed else b. Magnitudes use two's complement negate; |0x8000_0000| = 0x8000_0000 as unsigned.
  - Operand outputs stay stable until div_done_in.
  - Next state: WAIT.
- WAIT:
  - On div_done_in, apply sign fixup when signed: quotient negated if a[MSB]^b[MSB]; remainder negated if a[MSB].
  - Write {a, b, signed, quotient, remainder} into the cache and set cache valid.
  - Next state: DONE.
- DONE:
  - resp_valid_out=1; resp_result_out = quotient for op[1]=0, remainder for op[1]=1.
  - Result is held stable until resp_ready_in.
  - On resp_ready_in, go to IDLE. A new request is not accepted in that same cycle; req_ready_out=0 outside IDLE.
- Latency (accept in cycle N):
  - Special case or cache hit: resp_valid_out in N+1.
  - Divider path: start pulse in N+1; if div_done_in arrives in cycle D, resp_valid_out in D+1.
- Special-case results never write the cache.
- flush_in, which has priority over all other events:
  - IDLE: the request is not accepted.
  - ISSUE: go to DRAIN if the start pulse has already been driven; otherwise go to IDLE with no pulse. The pulse is driven on the ISSUE cycle itself, so a flush in ISSUE suppresses it.
  - WAIT: go to DRAIN.
  - DONE: go to IDLE; the response is dropped.
  - No response is produced for a flushed request, and the cache is not written.
- DRAIN:
  - req_ready_out=0.
  - Discard the result and go to IDLE on div_done_in. If div_done_in coincides with the flush in WAIT, go directly to IDLE.
- A div_done_in pulse in IDLE, ISSUE or DONE is ignored.
- flush_in held across multiple cycles keeps the sequencer in IDLE/DRAIN.

Test Plan:
- DIV a=-7 (0xFFFF_FFF9), b=2 with a divider model of 10 cycles:
  - div_dividend_out=7, div_divisor_out=2.
  - resp_result_out=0xFFFF_FFFD (-3) in cycle D+1.
  - A following REM with the same operands returns 0xFFFF_FFFF (-1) one cycle after accept, with no div_start_out.
- DIVU a=100, b=0 → resp=0xFFFF_FFFF one cycle after accept, no start pulse. REMU a=100, b=0 → resp=100. The cache stays invalid, so the next DIVU 100/7 starts the divider.
- DIV a=0x8000_0000, b=0xFFFF_FFFF → resp=0x8000_0000; REM with the same operands → resp=0; no start pulse.
- Cache keyed on signedness: DIVU a=0xFFFF_FFF9, b=2 → resp=0x7FFF_FFFC; then DIV with the same operands must start the divider (miss) and return 0xFFFF_FFFD.
- Flush in WAIT:
  - req_ready_out stays 0 until the discarded div_done_in; no resp_valid_out.
  - The next DIVU 9/3 starts the divider and returns 3.
- Backpressure: resp_ready_in held 0 for 5 cycles in DONE keeps resp_result_out stable. rst_in asserted mid-WAIT clears all outputs immediately, and the cache is invalid afterward.

Source files
------------

// File: rtl/riscv_div_sequencer.sv
`default_nettype none
// ============================================================================
// riscv_div_sequencer
// RISC-V DIV/DIVU/REM/REMU controller for an iterative unsigned divider, with
// special-case bypass, sign fixup and a one-entry quotient/remainder cache.
// Rev 1.0
// ============================================================================
module riscv_div_sequencer #(
    parameter int WIDTH    = 32,
    parameter bit CACHE_EN = 1'b1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             req_valid_in,
    output logic             req_ready_out,
    input  logic [1:0]       req_op_in,
    input  logic [WIDTH-1:0] req_a_in,
    input  logic [WIDTH-1:0] req_b_in,
    output logic             resp_valid_out,
    input  logic             resp_ready_in,
    output logic [WIDTH-1:0] resp_result_out,
    input  logic             flush_in,
    output logic             div_start_out,
    output logic [WIDTH-1:0] div_dividend_out,
    output logic [WIDTH-1:0] div_divisor_out,
    input  logic             div_done_in,
    input  logic [WIDTH-1:0] div_quotient_in,
    input  logic [WIDTH-1:0] div_remainder_in
);
    localparam logic [WIDTH-1:0] c_ZERO = '0;
    localparam logic [WIDTH-1:0] c_ONES = '1;
    localparam logic [WIDTH-1:0] c_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_e;

    state_e           state_q;
    logic             ready_q, resp_valid_q, signed_q, rem_sel_q;
    logic [WIDTH-1:0] a_q, b_q, result_q, dividend_q, divisor_q;
    logic             cache_vld_q, cache_signed_q;
    logic [WIDTH-1:0] cache_a_q, cache_b_q, cache_quo_q, cache_rem_q;

    logic             req_signed, accept, is_div0, is_ovf, is_hit, is_fast;
    logic [WIDTH-1:0] fast_quo, fast_rem, fast_res, mag_a, mag_b, quo_fix, rem_fix;

    always_comb begin
        req_signed = ~req_op_in[0];
        accept     = (state_q == S_IDLE) && ready_q && req_valid_in && !flush_in;
        is_div0    = (req_b_in == c_ZERO);
        is_ovf     = req_signed && (req_a_in == c_MIN) && (req_b_in == c_ONES);
        is_hit     = CACHE_EN && cache_vld_q && (cache_a_q == req_a_in) &&
                     (cache_b_q == req_b_in) && (cache_signed_q == req_signed);
        is_fast    = is_div0 || is_ovf || is_hit;

        // Priority: divide-by-zero, then signed overflow, then cached result.
        fast_quo = cache_quo_q;
        fast_rem = cache_rem_q;
        if (is_div0) begin
            fast_quo = c_ONES;
            fast_rem = req_a_in;
        end else if (is_ovf) begin
            fast_quo = c_MIN;
            fast_rem = c_ZERO;
        end
        fast_res = req_op_in[1] ? fast_rem : fast_quo;

        mag_a = (req_signed && req_a_in[WIDTH-1]) ? (c_ZERO - req_a_in) : req_a_in;
        mag_b = (req_signed && req_b_in[WIDTH-1]) ? (c_ZERO - req_b_in) : req_b_in;

        quo_fix = (signed_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ?
                  (c_ZERO - div_quotient_in) : div_quotient_in;
        rem_fix = (signed_q && a_q[WIDTH-1]) ?
                  (c_ZERO - div_remainder_in) : div_remainder_in;
    end

    assign req_ready_out    = ready_q;
    assign resp_valid_out   = resp_valid_q;
    assign resp_result_out  = result_q;
    // Combinational so that a flush in the ISSUE cycle can still cancel the pulse.
    assign div_start_out    = (state_q == S_ISSUE) && !flush_in;
    assign div_dividend_out = dividend_q;
    assign div_divisor_out  = divisor_q;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q        <= S_IDLE;
            ready_q        <= 1'b0;
            resp_valid_q   <= 1'b0;
            result_q       <= c_ZERO;
            dividend_q     <= c_ZERO;
            divisor_q      <= c_ZERO;
            a_q            <= c_ZERO;
            b_q            <= c_ZERO;
            signed_q       <= 1'b0;
            rem_sel_q      <= 1'b0;
            cache_vld_q    <= 1'b0;
            cache_signed_q <= 1'b0;
            cache_a_q      <= c_ZERO;
            cache_b_q      <= c_ZERO;
            cache_quo_q    <= c_ZERO;
            cache_rem_q    <= c_ZERO;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        a_q       <= req_a_in;
                        b_q       <= req_b_in;
                        signed_q  <= req_signed;
                        rem_sel_q <= req_op_in[1];
                        ready_q   <= 1'b0;
                        if (is_fast) begin
                            result_q     <= fast_res;
                            resp_valid_q <= 1'b1;
                            state_q      <= S_DONE;
                        end else begin
                            dividend_q <= mag_a;
                            divisor_q  <= mag_b;
                            state_q    <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (flush_in) begin
                        ready_q <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (flush_in) begin
                        if (div_done_in) begin
                            ready_q <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            state_q <= S_DRAIN;
                        end
                    end else if (div_done_in) begin
                        result_q       <= rem_sel_q ? rem_fix : quo_fix;
                        resp_valid_q   <= 1'b1;
                        cache_vld_q    <= 1'b1;
                        cache_a_q      <= a_q;
                        cache_b_q      <= b_q;
                        cache_signed_q <= signed_q;
                        cache_quo_q    <= quo_fix;
                        cache_rem_q    <= rem_fix;
                        state_q        <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (flush_in || resp_ready_in) begin
                        resp_valid_q <= 1'b0;
                        ready_q      <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (div_done_in) begin
                        ready_q <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    resp_valid_q <= 1'b0;
                    ready_q      <= 1'b0;
                    state_q      <= S_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_riscv_div_sequencer.sv
`default_nettype none
// ============================================================================
// tb_riscv_div_sequencer
// Directed and randomized checks of riscv_div_sequencer against an arithmetic
// reference, with a latency-programmable unsigned divider model.
// Rev 1.0
// ============================================================================
module tb_riscv_div_sequencer;
    localparam logic [31:0] c_MIN  = 32'h8000_0000;
    localparam logic [31:0] c_ONES = 32'hFFFF_FFFF;
    localparam logic [1:0]  c_DIV  = 2'b00;
    localparam logic [1:0]  c_DIVU = 2'b01;
    localparam logic [1:0]  c_REM  = 2'b10;
    localparam logic [1:0]  c_REMU = 2'b11;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        req_valid_in, req_ready_out, resp_valid_out, resp_ready_in, flush_in;
    logic [1:0]  req_op_in;
    logic [31:0] req_a_in, req_b_in, resp_result_out;
    logic        div_start_out, div_done_in;
    logic [31:0] div_dividend_out, div_divisor_out, div_quotient_in, div_remainder_in;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    // Divider model state
    int          dv_lat, dv_cnt, dv_starts, dv_done_cyc;
    logic [31:0] dv_dvd, dv_dvs;

    // Model of the expected cache content
    logic        mc_vld, mc_s;
    logic [31:0] mc_a, mc_b;

    riscv_div_sequencer #(.WIDTH(32), .CACHE_EN(1'b1)) u_dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .req_valid_in     (req_valid_in),
        .req_ready_out    (req_ready_out),
        .req_op_in        (req_op_in),
        .req_a_in         (req_a_in),
        .req_b_in         (req_b_in),
        .resp_valid_out   (resp_valid_out),
        .resp_ready_in    (resp_ready_in),
        .resp_result_out  (resp_result_out),
        .flush_in         (flush_in),
        .div_start_out    (div_start_out),
        .div_dividend_out (div_dividend_out),
        .div_divisor_out  (div_divisor_out),
        .div_done_in      (div_done_in),
        .div_quotient_in  (div_quotient_in),
        .div_remainder_in (div_remainder_in)
    );

    always #5 clk_in = ~clk_in;

    initial forever begin
        @(posedge clk_in);
        cyc++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", n_total);
        $fatal(1, "watchdog");
    end

    // Unsigned divider: samples start on the falling edge, answers dv_lat cycles later.
    initial begin
        div_done_in = 1'b0; div_quotient_in = '0; div_remainder_in = '0;
        dv_cnt = 0; dv_starts = 0; dv_done_cyc = 0; dv_dvd = '0; dv_dvs = '0;
        forever begin
            @(negedge clk_in);
            div_done_in = 1'b0;
            if (dv_cnt > 0) begin
                dv_cnt--;
                if (dv_cnt == 0) begin
                    div_done_in      = 1'b1;
                    div_quotient_in  = (dv_dvs == 0) ? c_ONES : dv_dvd / dv_dvs;
                    div_remainder_in = (dv_dvs == 0) ? dv_dvd : dv_dvd % dv_dvs;
                    dv_done_cyc      = cyc;
                end
            end
            if (div_start_out === 1'b1) begin
                dv_dvd = div_dividend_out;
                dv_dvs = div_divisor_out;
                dv_cnt = dv_lat;
                dv_starts++;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return op[1] ? a : c_ONES;
        if (op[0]) begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end
        q = sa / sb;
        r = sa % sb;
        return op[1] ? r[31:0] : q[31:0];
    endfunction

    function automatic logic [31:0] mag(input logic is_signed, input logic [31:0] x);
        longint sx;
        sx = longint'($signed(x));
        if (is_signed && sx < 0) sx = -sx;
        else sx = longint'({32'd0, x});
        return sx[31:0];
    endfunction

    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int n_acc);
        int k;
        req_valid_in = 1'b1; req_op_in = op; req_a_in = a; req_b_in = b;
        k = 0;
        while (req_ready_out !== 1'b1 && k < 50) begin step(); k++; end
        chk("req_ready", 64'(req_ready_out), 64'(1));
        n_acc = cyc;
        step();
        req_valid_in = 1'b0;
    endtask

    task automatic do_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int bp);
        logic        exp_special, exp_hit, exp_start;
        logic [31:0] exp_res;
        int          n_acc, s0, k, rc;
        exp_res     = ref_res(op, a, b);
        exp_special = (b == 32'd0) || (!op[0] && a == c_MIN && b == c_ONES);
        exp_hit     = !exp_special && mc_vld && mc_a == a && mc_b == b && mc_s == !op[0];
        exp_start   = !exp_special && !exp_hit;
        s0 = dv_starts;
        send(op, a, b, n_acc);
        k = 0;
        while (resp_valid_out !== 1'b1 && k < 200) begin step(); k++; end
        chk("resp_valid", 64'(resp_valid_out), 64'(1));
        rc = cyc;
        chk("result", 64'(resp_result_out), 64'(exp_res));
        chk("start_count", 64'(dv_starts - s0), 64'(exp_start));
        if (exp_start) begin
            chk("latency_div", 64'(rc), 64'(dv_done_cyc + 1));
            chk("dividend", 64'(dv_dvd), 64'(mag(!op[0], a)));
            chk("divisor", 64'(dv_dvs), 64'(mag(!op[0], b)));
            mc_vld = 1'b1; mc_a = a; mc_b = b; mc_s = !op[0];
        end else begin
            chk("latency_fast", 64'(rc), 64'(n_acc + 1));
        end
        for (int i = 0; i < bp; i++) begin
            step();
            chk("hold_valid", 64'(resp_valid_out), 64'(1));
            chk("hold_result", 64'(resp_result_out), 64'(exp_res));
        end
        resp_ready_in = 1'b1;
        step();
        resp_ready_in = 1'b0;
        chk("resp_cleared", 64'(resp_valid_out), 64'(0));
        chk("ready_back", 64'(req_ready_out), 64'(1));
    endtask

    task automatic wait_div_idle();
        int k;
        k = 0;
        while ((dv_cnt != 0 || div_done_in) && k < 100) begin step(); k++; end
        chk("div_idle", 64'(dv_cnt), 64'(0));
    endtask

    initial begin
        int          n_acc, s0, k, d_cyc;
        logic        saw;
        logic [1:0]  op;
        logic [31:0] a, b;

        rst_in = 1'b0; req_valid_in = 1'b0; req_op_in = '0; req_a_in = '0; req_b_in = '0;
        resp_ready_in = 1'b0; flush_in = 1'b0; dv_lat = 10; mc_vld = 1'b0;
        mc_s = 1'b0; mc_a = '0; mc_b = '0;
        repeat (2) @(posedge clk_in);
        #1;
        chk("rst_ready", 64'(req_ready_out), 64'(0));
        chk("rst_valid", 64'(resp_valid_out), 64'(0));
        chk("rst_result", 64'(resp_result_out), 64'(0));
        chk("rst_start", 64'(div_start_out), 64'(0));
        chk("rst_dvd", 64'(div_dividend_out), 64'(0));
        chk("rst_dvs", 64'(div_divisor_out), 64'(0));
        rst_in = 1'b1;
        step(); step();
        chk("ready_after_rst", 64'(req_ready_out), 64'(1));

        // Signed divide, then cached remainder
        do_req(c_DIV, 32'hFFFF_FFF9, 32'd2, 0);
        do_req(c_REM, 32'hFFFF_FFF9, 32'd2, 0);
        // Divide by zero never touches the cache
        do_req(c_DIVU, 32'd100, 32'd0, 0);
        do_req(c_REMU, 32'd100, 32'd0, 0);
        do_req(c_DIVU, 32'd100, 32'd7, 0);
        // Signed overflow
        do_req(c_DIV, c_MIN, c_ONES, 0);
        do_req(c_REM, c_MIN, c_ONES, 0);
        // Cache keyed on signedness
        do_req(c_DIVU, 32'hFFFF_FFF9, 32'd2, 0);
        do_req(c_DIV, 32'hFFFF_FFF9, 32'd2, 0);
        // Backpressure
        do_req(c_DIV, 32'd12345, 32'hFFFF_FFB3, 5);

        // Flush in WAIT: drain the in-flight divide, no response
        dv_lat = 8; s0 = dv_starts;
        send(c_DIVU, 32'd20, 32'd4, n_acc);
        step();
        flush_in = 1'b1; step(); flush_in = 1'b0;
        saw = 1'b0; k = 0;
        while (req_ready_out !== 1'b1 && k < 40) begin
            if (resp_valid_out) saw = 1'b1;
            step(); k++;
        end
        chk("drain_ready", 64'(req_ready_out), 64'(1));
        chk("drain_ready_cycle", 64'(cyc), 64'(dv_done_cyc + 1));
        chk("drain_no_resp", 64'(saw | resp_valid_out), 64'(0));
        chk("drain_started", 64'(dv_starts - s0), 64'(1));
        do_req(c_DIVU, 32'd9, 32'd3, 0);
        do_req(c_DIVU, 32'd20, 32'd4, 0);

        // Flush coinciding with divider done
        dv_lat = 4;
        send(c_DIVU, 32'd50, 32'd5, n_acc);
        d_cyc = n_acc + 1 + dv_lat;
        while (cyc < d_cyc) step();
        flush_in = 1'b1; step(); flush_in = 1'b0;
        chk("flush_done_cycle", 64'(dv_done_cyc), 64'(d_cyc));
        chk("flush_done_ready", 64'(req_ready_out), 64'(1));
        chk("flush_done_valid", 64'(resp_valid_out), 64'(0));
        do_req(c_DIVU, 32'd50, 32'd5, 0);

        // Flush in ISSUE cancels the start pulse
        s0 = dv_starts;
        send(c_DIVU, 32'd31, 32'd6, n_acc);
        flush_in = 1'b1; step(); flush_in = 1'b0;
        chk("issue_flush_ready", 64'(req_ready_out), 64'(1));
        step(); step();
        chk("issue_flush_nostart", 64'(dv_starts - s0), 64'(0));
        chk("issue_flush_valid", 64'(resp_valid_out), 64'(0));

        // Flush in IDLE blocks acceptance
        req_valid_in = 1'b1; req_op_in = c_DIVU; req_a_in = 32'd5; req_b_in = 32'd0;
        flush_in = 1'b1; step(); step();
        chk("idle_flush_valid", 64'(resp_valid_out), 64'(0));
        req_valid_in = 1'b0; flush_in = 1'b0; step();
        chk("idle_flush_valid2", 64'(resp_valid_out), 64'(0));

        // Flush in DONE drops the response
        send(c_DIVU, 32'd5, 32'd0, n_acc);
        chk("done_valid", 64'(resp_valid_out), 64'(1));
        flush_in = 1'b1; step(); flush_in = 1'b0;
        chk("done_flush_valid", 64'(resp_valid_out), 64'(0));
        chk("done_flush_ready", 64'(req_ready_out), 64'(1));

        // Reset mid-WAIT clears outputs and the cache
        dv_lat = 10;
        do_req(c_DIV, 32'd1000, 32'hFFFF_FFFD, 0);
        send(c_DIVU, 32'd77, 32'd5, n_acc);
        step(); step();
        rst_in = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(req_ready_out), 64'(0));
        chk("mid_rst_valid", 64'(resp_valid_out), 64'(0));
        chk("mid_rst_result", 64'(resp_result_out), 64'(0));
        chk("mid_rst_start", 64'(div_start_out), 64'(0));
        chk("mid_rst_dvd", 64'(div_dividend_out), 64'(0));
        chk("mid_rst_dvs", 64'(div_divisor_out), 64'(0));
        mc_vld = 1'b0;
        step();
        rst_in = 1'b1;
        step(); step();
        wait_div_idle();
        do_req(c_REM, 32'd1000, 32'hFFFF_FFFD, 0);

        // Randomized traffic with operand reuse to exercise the cache
        a = 32'd1; b = 32'd1;
        for (int it = 0; it < 80; it++) begin
            op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) != 0 || it == 0) begin
                case ($urandom_range(0, 5))
                    0: begin a = $urandom; b = 32'd0; end
                    1: begin a = c_MIN; b = c_ONES; end
                    2: begin a = $urandom; b = 32'($urandom_range(1, 20)); end
                    3: begin a = 32'($urandom_range(0, 200)); b = 32'd0 - 32'($urandom_range(1, 9)); end
                    default: begin a = $urandom; b = $urandom; end
                endcase
            end
            dv_lat = $urandom_range(1, 6);
            do_req(op, a, b, $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
